// File: rtl/wb_fir_ctrl.sv
// Wishbone slave sharing the user WB port between the user BRAM and the FIR core.
// One transaction at a time: decode in IDLE, sequence the selected side, one-cycle ack.
module wb_fir_ctrl #(
    parameter int unsigned DELAYS   = 10,
    parameter int unsigned TIMEOUT  = 1024,
    parameter logic [7:0]  BRAM_HI  = 8'h38,
    parameter logic [31:0] FIR_BASE = 32'h3000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        bram_en,
    output logic [3:0]  bram_we,
    output logic [31:0] bram_di,
    input  logic [31:0] bram_do,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] awaddr,
    output logic        wvalid,
    input  logic        wready,
    output logic [31:0] wdata,
    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddr,
    input  logic        rvalid,
    output logic        rready,
    input  logic [31:0] rdata,
    output logic        ss_tvalid,
    input  logic        ss_tready,
    output logic [31:0] ss_tdata,
    output logic        ss_tlast,
    input  logic        sm_tvalid,
    output logic        sm_tready,
    input  logic [31:0] sm_tdata,
    input  logic        sm_tlast
);
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam int DW = $clog2(DELAYS) + 1;

    typedef enum logic [2:0] {IDLE, BRAM, AXW, AXAR, AXR, XPUSH, YPOP, ACK} state_t;

    state_t        state_q, state_d;
    logic [31:0]   off_q, off_d;
    logic [31:0]   rdat_q, rdat_d;
    logic [31:0]   len_q, len_d;
    logic [31:0]   scnt_q, scnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          we_q, we_d;
    logic          aw_done_q, aw_done_d;
    logic          w_done_q, w_done_d;

    logic          valid;
    logic [31:0]   off_in;
    logic          tmo_hit;
    logic          aw_hs, w_hs;
    logic          unused_sm_tlast;

    assign valid           = wbs_cyc_i & wbs_stb_i;
    assign off_in          = wbs_adr_i - FIR_BASE;
    assign tmo_hit         = (tmo_q == TW'(TIMEOUT - 1));
    assign unused_sm_tlast = sm_tlast;

    // All handshake outputs decode from registered state, so a sampled rst clears them at that edge.
    assign awvalid   = (state_q == AXW) && !aw_done_q;
    assign wvalid    = (state_q == AXW) && !w_done_q;
    assign awaddr    = off_q;
    assign wdata     = (state_q == AXW) ? wbs_dat_i : 32'd0;
    assign arvalid   = (state_q == AXAR);
    assign araddr    = off_q;
    assign rready    = (state_q == AXR);
    assign ss_tvalid = (state_q == XPUSH);
    assign ss_tdata  = (state_q == XPUSH) ? wbs_dat_i : 32'd0;
    assign ss_tlast  = (state_q == XPUSH) && (len_q != 32'd0) && (scnt_q == len_q - 32'd1);
    assign sm_tready = (state_q == YPOP);
    assign bram_en   = (state_q == BRAM) && valid;
    assign bram_we   = (state_q == BRAM) ? (wbs_sel_i & {4{wbs_we_i}}) : 4'd0;
    assign bram_di   = (state_q == BRAM) ? wbs_dat_i : 32'd0;
    assign wbs_ack_o = (state_q == ACK);
    assign wbs_dat_o = ((state_q == ACK) && !we_q) ? rdat_q : 32'd0;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    always_comb begin
        state_d   = state_q;
        off_d     = off_q;
        rdat_d    = rdat_q;
        len_d     = len_q;
        scnt_d    = scnt_q;
        we_d      = we_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        dcnt_d    = dcnt_q;
        tmo_d     = (state_q == IDLE) ? '0 : tmo_q + TW'(1);

        case (state_q)
            IDLE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                dcnt_d    = '0;
                if (valid && !wbs_ack_o) begin
                    we_d   = wbs_we_i;
                    off_d  = off_in;
                    rdat_d = 32'd0;
                    if (wbs_adr_i[31:24] == BRAM_HI)         state_d = BRAM;
                    else if (off_in < 32'h80)                state_d = wbs_we_i ? AXW : AXAR;
                    else if (off_in == 32'h80 && wbs_we_i)   state_d = XPUSH;
                    else if (off_in == 32'h84 && !wbs_we_i)  state_d = YPOP;
                    else                                     state_d = ACK;
                end
            end
            BRAM: begin
                dcnt_d = dcnt_q + DW'(1);
                if (dcnt_q == DW'(DELAYS - 1)) begin
                    rdat_d  = bram_do;
                    state_d = ACK;
                end
            end
            AXW: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs) begin
                    w_done_d = 1'b1;
                    // Writing the length register restarts the X frame.
                    if (off_q == 32'h10) begin
                        len_d  = wbs_dat_i;
                        scnt_d = 32'd0;
                    end
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    state_d = ACK;
                end else if (tmo_hit) begin
                    rdat_d  = 32'hFFFF_FFFF;
                    state_d = ACK;
                end
            end
            AXAR: begin
                if (arready) begin
                    state_d = AXR;
                end else if (tmo_hit) begin
                    rdat_d  = 32'hFFFF_FFFF;
                    state_d = ACK;
                end
            end
            AXR: begin
                if (rvalid) begin
                    rdat_d  = rdata;
                    state_d = ACK;
                end else if (tmo_hit) begin
                    rdat_d  = 32'hFFFF_FFFF;
                    state_d = ACK;
                end
            end
            XPUSH: begin
                if (ss_tready) begin
                    scnt_d  = ss_tlast ? 32'd0 : scnt_q + 32'd1;
                    state_d = ACK;
                end else if (tmo_hit) begin
                    rdat_d  = 32'hFFFF_FFFF;
                    state_d = ACK;
                end
            end
            YPOP: begin
                if (sm_tvalid) begin
                    rdat_d  = sm_tdata;
                    state_d = ACK;
                end else if (tmo_hit) begin
                    rdat_d  = 32'hFFFF_FFFF;
                    state_d = ACK;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            off_q     <= 32'd0;
            rdat_q    <= 32'd0;
            len_q     <= 32'd0;
            scnt_q    <= 32'd0;
            tmo_q     <= '0;
            dcnt_q    <= '0;
            we_q      <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            off_q     <= off_d;
            rdat_q    <= rdat_d;
            len_q     <= len_d;
            scnt_q    <= scnt_d;
            tmo_q     <= tmo_d;
            dcnt_q    <= dcnt_d;
            we_q      <= we_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end
endmodule

// File: tb/tb_wb_fir_ctrl.sv
// Directed bench for wb_fir_ctrl: WB master plus BRAM/AXI-Lite/stream responders in one task,
// expected read data and tlast values queued at stimulus time and popped at ack.
module tb_wb_fir_ctrl;
    localparam int TMO = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic [31:0] bram_di, bram_do;
    logic        awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic        ss_tvalid, ss_tready, ss_tlast, sm_tvalid, sm_tready, sm_tlast;
    logic [31:0] ss_tdata, sm_tdata;

    wb_fir_ctrl #(.DELAYS(10), .TIMEOUT(TMO), .BRAM_HI(8'h38), .FIR_BASE(32'h3000_0000)) dut (
        .clk(clk), .rst(rst),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .bram_en(bram_en), .bram_we(bram_we), .bram_di(bram_di), .bram_do(bram_do),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .ss_tvalid(ss_tvalid), .ss_tready(ss_tready), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast),
        .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mem [0:255];

    // Responder setup: index of the valid/ready cycle on which the partner answers (0 = never).
    int          aw_at, w_at, ar_at, r_at, ss_at, sm_at;
    logic [31:0] rdata_v, sm_v;
    int          awv_n, wv_n, arv_n, rr_n, ssv_n, smr_n;
    logic [31:0] aw_seen, ar_seen, tdata_seen;
    logic        tlast_seen;
    int          lat;
    logic [31:0] rd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One WB cycle; lat = cycles from the strobe cycle to the ack cycle (0 if no ack in maxc).
    task automatic wb(input logic we, input logic [31:0] adr, input logic [31:0] dat, input int maxc);
        bit done;
        done = 1'b0;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = 4'hF;
        lat = 0; rd = 32'hDEAD_BEEF;
        awv_n = 0; wv_n = 0; arv_n = 0; rr_n = 0; ssv_n = 0; smr_n = 0;
        for (int c = 1; c <= maxc && !done; c++) begin
            @(posedge clk); #1;
            awready = 1'b0; wready = 1'b0; arready = 1'b0; rvalid = 1'b0; rdata = 32'd0;
            ss_tready = 1'b0; sm_tvalid = 1'b0; sm_tdata = 32'd0;
            if (wbs_ack_o) begin
                lat = c; rd = wbs_dat_o; done = 1'b1;
            end else begin
                if (awvalid) begin awv_n++; aw_seen = awaddr; if (awv_n == aw_at) awready = 1'b1; end
                if (wvalid)  begin wv_n++;  if (wv_n == w_at) wready = 1'b1; end
                if (arvalid) begin arv_n++; ar_seen = araddr; if (arv_n == ar_at) arready = 1'b1; end
                if (rready)  begin rr_n++;  if (rr_n == r_at) begin rvalid = 1'b1; rdata = rdata_v; end end
                if (ss_tvalid) begin
                    ssv_n++;
                    if (ssv_n == ss_at) begin ss_tready = 1'b1; tlast_seen = ss_tlast; tdata_seen = ss_tdata; end
                end
                if (sm_tready) begin smr_n++; if (smr_n == sm_at) begin sm_tvalid = 1'b1; sm_tdata = sm_v; end end
                if (bram_en) begin
                    for (int b = 0; b < 4; b++)
                        if (bram_we[b]) mem[wbs_adr_i[9:2]][8*b +: 8] = bram_di[8*b +: 8];
                    bram_do = mem[wbs_adr_i[9:2]];
                end
            end
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        rst = 1'b1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; wbs_sel_i = 4'h0;
        wbs_adr_i = 32'd0; wbs_dat_i = 32'd0; bram_do = 32'd0;
        awready = 1'b0; wready = 1'b0; arready = 1'b0; rvalid = 1'b0; rdata = 32'd0;
        ss_tready = 1'b0; sm_tvalid = 1'b0; sm_tdata = 32'd0; sm_tlast = 1'b0;
        aw_at = 1; w_at = 1; ar_at = 1; r_at = 1; ss_at = 1; sm_at = 1;
        rdata_v = 32'd0; sm_v = 32'd0;
        aw_seen = 32'd0; ar_seen = 32'd0; tdata_seen = 32'd0; tlast_seen = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
        chk("rst_dat", wbs_dat_o, 32'd0);
        chk("rst_ctl", {23'd0, awvalid, wvalid, arvalid, rready, ss_tvalid, ss_tlast,
                        sm_tready, bram_en, |bram_we}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // BRAM write then read-back
        wb(1'b1, 32'h3800_0010, 32'h1234_5678, 50);
        chk("bram_wr_lat", lat, 32'd11);
        chk("bram_wr_dat", rd, 32'd0);
        exp_q.push_back(32'h1234_5678);
        wb(1'b0, 32'h3800_0010, 32'd0, 50);
        chk("bram_rd_lat", lat, 32'd11);
        chk("bram_rd_dat", rd, exp_q.pop_front());

        // Config write with late awready
        aw_at = 4; w_at = 1;
        wb(1'b1, 32'h3000_0010, 32'd11, 50);
        chk("axw_lat", lat, 32'd5);
        chk("axw_awvalid_cyc", awv_n, 32'd4);
        chk("axw_wvalid_cyc", wv_n, 32'd1);
        chk("axw_awaddr", aw_seen, 32'h10);
        chk("axw_single_ack", {31'd0, wbs_ack_o}, 32'd0);

        // Data length 3, then four X pushes
        aw_at = 1;
        wb(1'b1, 32'h3000_0010, 32'd3, 50);
        chk("len_wr_lat", lat, 32'd2);
        for (int i = 0; i < 4; i++) begin
            ss_at = (i == 1) ? 3 : 1;
            exp_q.push_back({31'd0, (i == 2)});
            wb(1'b1, 32'h3000_0080, 32'hA0 + i, 50);
            chk("xpush_lat", lat, ss_at + 1);
            chk("xpush_tlast", {31'd0, tlast_seen}, exp_q.pop_front());
            chk("xpush_tdata", tdata_seen, 32'hA0 + i);
        end

        // Config read with handshake delays
        ar_at = 2; r_at = 3; rdata_v = 32'hCAFE_0011;
        exp_q.push_back(32'hCAFE_0011);
        wb(1'b0, 32'h3000_0024, 32'd0, 50);
        chk("axr_lat", lat, 32'd6);
        chk("axr_dat", rd, exp_q.pop_front());
        chk("axr_araddr", ar_seen, 32'h24);

        // Y pop with tvalid held off
        sm_at = 20; sm_v = 32'hFFFF_FFF6;
        exp_q.push_back(32'hFFFF_FFF6);
        wb(1'b0, 32'h3000_0084, 32'd0, 100);
        chk("ypop_lat", lat, 32'd21);
        chk("ypop_dat", rd, exp_q.pop_front());

        // Unmapped accesses
        exp_q.push_back(32'd0);
        wb(1'b0, 32'h3000_0080, 32'd0, 50);
        chk("unmap_rd_lat", lat, 32'd1);
        chk("unmap_rd_dat", rd, exp_q.pop_front());
        chk("unmap_rd_axi", awv_n + wv_n + arv_n + rr_n + ssv_n + smr_n, 32'd0);
        wb(1'b1, 32'h3000_0100, 32'h5555_AAAA, 50);
        chk("unmap_wr_lat", lat, 32'd1);

        // Config read with arready stuck low
        ar_at = 0;
        exp_q.push_back(32'hFFFF_FFFF);
        wb(1'b0, 32'h3000_0008, 32'd0, TMO + 50);
        chk("tmo_dat", rd, exp_q.pop_front());
        chk("tmo_arvalid_cyc", arv_n, TMO);
        chk("tmo_lat", lat, TMO + 1);

        // Reset in the middle of the same wait
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = 32'h3000_0008; wbs_sel_i = 4'hF;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_mid_pre", {31'd0, arvalid}, 32'd1);
        rst = 1'b1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_arvalid", {31'd0, arvalid}, 32'd0);
        chk("rst_mid_ack", {31'd0, wbs_ack_o}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        wb(1'b0, 32'h3000_0080, 32'd0, 50);
        chk("post_rst_lat", lat, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
